// File: rtl/othello_turn_controller.sv
// Turn sequencer for the Othello board: welcome/init handshake, N-player rotation, passes, game over.
// Optional turn time limit is built only when OTHELLO_TURN_TIMEOUT_EN is defined.
module othello_turn_controller #(
    parameter int unsigned NUM_PLAYERS    = 2,
    parameter int unsigned PW             = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          go,
    input  logic          init_end,
    input  logic          ack,
    input  logic          nack,
    input  logic          no_move,
    input  logic          game_end,
    output logic          init_start,
    output logic          new_move,
    output logic [PW-1:0] player,
    output logic [PW-1:0] pass_count,
    output logic          game_over,
    output logic          turn_timeout
);

    typedef enum logic [2:0] {
        StWelc  = 3'd0,
        StInit  = 3'd1,
        StWait  = 3'd2,
        StPress = 3'd3,
        StVali  = 3'd4,
        StAdv   = 3'd5,
        StOver  = 3'd6
    } state_t;

    localparam logic [PW-1:0] LastPlayer = PW'(NUM_PLAYERS - 1);
    localparam logic [PW-1:0] MaxPass    = PW'(NUM_PLAYERS);

    state_t        state_q, state_d;
    logic [PW-1:0] player_q, player_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [PW-1:0] pass_inc;
    logic          timeout_hit;

    // Saturate so the pass count can never wrap past the player count.
    assign pass_inc = (pass_q == MaxPass) ? pass_q : pass_q + PW'(1);

    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        pass_d   = pass_q;
        case (state_q)
            StWelc: begin
                if (go) state_d = StInit;
            end
            StInit: begin
                if (init_end) begin
                    state_d  = StWait;
                    player_d = '0;
                    pass_d   = '0;
                end
            end
            StWait: begin
                if (game_end) begin
                    state_d = StOver;
                end else if (no_move || timeout_hit) begin
                    pass_d  = pass_inc;
                    state_d = (pass_inc == MaxPass) ? StOver : StAdv;
                end else if (go) begin
                    state_d = StPress;
                end
            end
            StPress: begin
                if (game_end) state_d = StOver;
                else if (!go) state_d = StVali;
            end
            StVali: begin
                if (game_end) begin
                    state_d = StOver;
                end else if (ack) begin
                    pass_d  = '0;
                    state_d = StAdv;
                end else if (nack) begin
                    state_d = StWait;
                end
            end
            StAdv: begin
                player_d = (player_q == LastPlayer) ? '0 : player_q + PW'(1);
                state_d  = game_end ? StOver : StWait;
            end
            StOver: begin
                if (go) state_d = StInit;
            end
            default: state_d = StWelc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StWelc;
            player_q <= '0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            pass_q   <= pass_d;
        end
    end

`ifdef OTHELLO_TURN_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q;

    assign timeout_hit = (state_q == StWait) && (timer_q == TimerLast) &&
                         !game_end && !no_move && !go;

    // Counts idle wait cycles, holds through press/validate, clears on any other path.
    always_comb begin
        timer_d = '0;
        case (state_q)
            StWait: begin
                if (state_d == StWait) timer_d = timer_q + TW'(1);
                else if (state_d == StPress) timer_d = timer_q;
            end
            StPress, StVali: begin
                if (state_d == StPress || state_d == StVali) timer_d = timer_q;
            end
            default: timer_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_hit;
        end
    end

    assign turn_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign turn_timeout       = 1'b0;
`endif

    assign init_start = (state_q == StInit);
    assign new_move   = (state_q == StVali);
    assign game_over  = (state_q == StOver);
    assign player     = player_q;
    assign pass_count = pass_q;

endmodule
